scramble_sequencer: RTL and testbench
=====================================

SCRAMBLE_SEQUENCER -- requirements
Module: scramble_sequencer

Interface
REQ-001 SHALL have parameter NUM_POS, default 6, the number of scrambler positions (legal indices 0..NUM_POS-1).
REQ-002 SHALL have parameter LFSR_SEED, default 8'hA5, the LFSR value loaded on reset.
REQ-003 SHALL have ports: clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have ports: rst  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have ports: start  in  1  level from the synchronised button; its rising edge requests a new game.
REQ-006 SHALL have ports: change  in  1  level from the synchronised button; its rising edge requests a user swap.
REQ-007 SHALL have ports: mode  in  2  scramble depth select: 00=4, 01=8, 10=16, 11=32 swaps.
REQ-008 SHALL have ports: pi1, pi2  in  3 each  user swap position indices.
REQ-009 SHALL have ports: is_correct  in  1  datapath flag: arrangement is solved.
REQ-010 SHALL have ports: swap_ready  in  1  datapath accepts the swap command this cycle.
REQ-011 SHALL have ports: swap_valid  out  1; swap_a, swap_b  out  3 each  swap command to the datapath.
REQ-012 SHALL have ports: busy  out  1  scrambling in progress; solved  out  1  game won.
REQ-013 SHALL have ports: illegal  out  1  one-cycle pulse on a rejected user swap; move_count  out  8  accepted user swaps.

Function
REQ-014 SHALL detect the start and change rising edges against a one-cycle registered copy; a held-high level counts once.
REQ-015 SHALL implement states IDLE, SCRAMBLE, ISSUE_S, PLAY, ISSUE_U, CHECK, SOLVED.
REQ-016 SHALL transition IDLE, PLAY or SOLVED -> SCRAMBLE on a start edge, latching mode into a swap target, clearing move_count and solved, and asserting busy.
REQ-017 SHALL ignore start and change edges in SCRAMBLE and ISSUE_S; SHALL ignore change in IDLE and SOLVED.
REQ-018 SHALL advance the 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) every cycle in all states.
REQ-019 SHALL, in SCRAMBLE, form a=lfsr[2:0] and b=lfsr[5:3], going to ISSUE_S only if a<NUM_POS, b<NUM_POS and a!=b; otherwise it SHALL stay in SCRAMBLE.
REQ-020 SHALL hold swap_valid high with stable swap_a/swap_b until swap_ready is sampled high, then drop swap_valid on the next cycle; valid SHALL be low for at least one cycle between commands.
REQ-021 SHALL count a scramble swap on acceptance and return to SCRAMBLE until the count equals the latched target.
REQ-022 SHALL, when the target is reached, sample is_correct one cycle after the last accept: if high, issue one extra scramble swap and re-check; if low, enter PLAY and drop busy.
REQ-023 SHALL, in PLAY on a change edge, go to ISSUE_U with swap_a=pi1 and swap_b=pi2 if pi1<NUM_POS, pi2<NUM_POS and pi1!=pi2; otherwise it SHALL pulse illegal for one cycle and stay in PLAY.
REQ-024 SHALL, on acceptance in ISSUE_U, increment move_count (saturating at 255) and go to CHECK.
REQ-025 SHALL, in CHECK, wait one cycle, then go to SOLVED with solved=1 if is_correct=1, else return to PLAY.
REQ-026 SHALL, on a start edge coinciding with a change edge in PLAY, give start priority.
REQ-027 SHALL treat swap_ready as don't-care while swap_valid=0.

Reset
REQ-028 SHALL on rst force state=IDLE, LFSR=LFSR_SEED, edge registers=0, all counters=0, and swap_valid, swap_a, swap_b, busy, solved, illegal, move_count=0.
REQ-029 SHALL abandon a pending handshake immediately when rst is asserted mid-operation, with no command completing.

Structure
REQ-030 SHALL place the state encoding, the mode-to-depth table, and the NUM_POS and LFSR_SEED defaults in the shared package scrambler_pkg.
REQ-031 SHALL instantiate one sub-module, lfsr8, which provides the free-running LFSR with a seed input.

Verification
REQ-032 SHALL check: reset, then a start edge with mode=00 and swap_ready=1, is_correct=0 -> exactly 4 handshakes, all indices <6 and a!=b, then busy falls and the state is PLAY.
REQ-033 SHALL check: a start edge with mode=11 and swap_ready held low for 3 cycles per command -> 32 handshakes with swap_a/swap_b stable while valid.
REQ-034 SHALL check: in PLAY, pi1=0, pi2=1, one change edge -> one command (0,1) and move_count=1; change held high for 10 cycles -> still only 1 command.
REQ-035 SHALL check: in PLAY, pi1=6, pi2=2 and pi1=3, pi2=3 -> illegal pulses once each, no swap_valid, move_count unchanged.
REQ-036 SHALL check: in PLAY, a change edge with is_correct=1 during CHECK -> solved=1; a later change edge is ignored; a start edge clears solved and move_count.
REQ-037 SHALL check: rst asserted while swap_valid=1 -> all outputs 0 within the same cycle, state IDLE.

Source files
------------

// File: rtl/scrambler_pkg.sv
// Shared definitions for the scramble sequencer: FSM encoding, default
// parameters, the mode-to-depth table and the swap-legality rule.
package scrambler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCRAMBLE,
    ISSUE_S,
    PLAY,
    ISSUE_U,
    CHECK,
    SOLVED
  } state_t;

  localparam int         NUM_POS_DEFAULT   = 6;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;
  localparam int         CNT_W             = 6;

  function automatic logic [CNT_W-1:0] depth_for_mode(input logic [1:0] mode);
    case (mode)
      2'b00:   return 6'd4;
      2'b01:   return 6'd8;
      2'b10:   return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic pair_legal(input logic [2:0] a, input logic [2:0] b,
                                      input int num_pos);
    return (int'(a) < num_pos) && (int'(b) < num_pos) && (a != b);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, loaded with seed_i on
// reset; exposes the two 3-bit fields used as candidate swap positions.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed_i,
  output logic [2:0] a_o,
  output logic [2:0] b_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= seed_i;
    else     lfsr_q <= lfsr_d;
  end

  assign a_o = lfsr_q[2:0];
  assign b_o = lfsr_q[5:3];

endmodule

// File: rtl/scramble_sequencer.sv
// Game sequencer: scrambles the arrangement with random legal swaps, then
// relays user swaps to the datapath and detects the solved condition.
module scramble_sequencer
  import scrambler_pkg::*;
#(
  parameter int         NUM_POS   = NUM_POS_DEFAULT,
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       change,
  input  logic [1:0] mode,
  input  logic [2:0] pi1,
  input  logic [2:0] pi2,
  input  logic       is_correct,
  input  logic       swap_ready,
  output logic       swap_valid,
  output logic [2:0] swap_a,
  output logic [2:0] swap_b,
  output logic       busy,
  output logic       solved,
  output logic       illegal,
  output logic [7:0] move_count
);

  state_t           state_q, state_d;
  logic             start_q, change_q;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             extra_q, extra_d;
  logic [2:0]       swap_a_q, swap_a_d, swap_b_q, swap_b_d;
  logic             illegal_q, illegal_d;
  logic [7:0]       move_count_q, move_count_d;
  logic [2:0]       rnd_a, rnd_b;
  logic             start_edge, change_edge, go_scramble, target_met;

  lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .seed_i (LFSR_SEED),
    .a_o    (rnd_a),
    .b_o    (rnd_b)
  );

  assign start_edge  = start & ~start_q;
  assign change_edge = change & ~change_q;
  assign go_scramble = start_edge &&
                       (state_q == IDLE || state_q == PLAY || state_q == SOLVED);
  assign target_met  = (count_q >= target_q);

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    count_d      = count_q;
    extra_d      = extra_q;
    swap_a_d     = swap_a_q;
    swap_b_d     = swap_b_q;
    illegal_d    = 1'b0;
    move_count_d = move_count_q;
    case (state_q)
      SCRAMBLE: begin
        // is_correct is only judged on the first cycle after the target is met;
        // a pending extra swap keeps searching regardless of it.
        if (target_met && !extra_q && !is_correct) begin
          state_d = PLAY;
        end else begin
          if (target_met && !extra_q) extra_d = 1'b1;
          if (pair_legal(rnd_a, rnd_b, NUM_POS)) begin
            swap_a_d = rnd_a;
            swap_b_d = rnd_b;
            state_d  = ISSUE_S;
          end
        end
      end
      ISSUE_S: if (swap_ready) begin
        count_d = (count_q == '1) ? count_q : count_q + 1'b1;
        extra_d = 1'b0;
        state_d = SCRAMBLE;
      end
      PLAY: if (change_edge) begin
        if (pair_legal(pi1, pi2, NUM_POS)) begin
          swap_a_d = pi1;
          swap_b_d = pi2;
          state_d  = ISSUE_U;
        end else begin
          illegal_d = 1'b1;
        end
      end
      ISSUE_U: if (swap_ready) begin
        move_count_d = (move_count_q == 8'hFF) ? move_count_q : move_count_q + 8'd1;
        state_d      = CHECK;
      end
      CHECK:   state_d = is_correct ? SOLVED : PLAY;
      default: ;
    endcase
    // A start edge overrides whatever PLAY decided for a simultaneous change.
    if (go_scramble) begin
      state_d      = SCRAMBLE;
      target_d     = depth_for_mode(mode);
      count_d      = '0;
      extra_d      = 1'b0;
      illegal_d    = 1'b0;
      move_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      change_q     <= 1'b0;
      target_q     <= '0;
      count_q      <= '0;
      extra_q      <= 1'b0;
      swap_a_q     <= '0;
      swap_b_q     <= '0;
      illegal_q    <= 1'b0;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      change_q     <= change;
      target_q     <= target_d;
      count_q      <= count_d;
      extra_q      <= extra_d;
      swap_a_q     <= swap_a_d;
      swap_b_q     <= swap_b_d;
      illegal_q    <= illegal_d;
      move_count_q <= move_count_d;
    end
  end

  assign swap_valid = (state_q == ISSUE_S) || (state_q == ISSUE_U);
  assign swap_a     = swap_a_q;
  assign swap_b     = swap_b_q;
  assign busy       = (state_q == SCRAMBLE) || (state_q == ISSUE_S);
  assign solved     = (state_q == SOLVED);
  assign illegal    = illegal_q;
  assign move_count = move_count_q;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Self-checking bench for scramble_sequencer: scramble games, table-driven and
// random user moves against a small behavioural model, solved and reset cases.
module tb_scramble_sequencer;
  import scrambler_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, change = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] pi1 = 3'd0, pi2 = 3'd0;
  logic       is_correct = 1'b0, swap_ready = 1'b0;
  logic       swap_valid, busy, solved, illegal;
  logic [2:0] swap_a, swap_b;
  logic [7:0] move_count;

  always #5 clk = ~clk;

  scramble_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .change(change), .mode(mode),
    .pi1(pi1), .pi2(pi2), .is_correct(is_correct), .swap_ready(swap_ready),
    .swap_valid(swap_valid), .swap_a(swap_a), .swap_b(swap_b), .busy(busy),
    .solved(solved), .illegal(illegal), .move_count(move_count)
  );

  typedef struct packed { logic [2:0] a; logic [2:0] b; } cmd_t;
  typedef struct { logic [2:0] p1; logic [2:0] p2; bit legal; } vec_t;

  cmd_t hs_q[$];
  int   n_pass = 0, n_total = 0;
  int   illegal_seen = 0, stab_err = 0, gap_err = 0;
  bit   ready_slow = 1'b0;
  int   exp_moves = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Datapath stand-in: drives swap_ready, logs accepted commands, audits the handshake.
  initial begin : monitor
    bit   pv, pa;
    cmd_t pc, c;
    int   vcnt;
    pv = 1'b0; pa = 1'b0; vcnt = 0; pc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; pa = 1'b0; vcnt = 0;
        swap_ready = 1'($urandom_range(0, 1));
      end else begin
        if (illegal) illegal_seen++;
        c.a = swap_a;
        c.b = swap_b;
        if (swap_valid) begin
          if (pa) gap_err++;
          else if (pv && c != pc) stab_err++;
          swap_ready = ready_slow ? (vcnt >= 3) : 1'b1;
          vcnt++;
          pa = swap_ready;
          if (swap_ready) hs_q.push_back(c);
        end else begin
          vcnt = 0;
          pa = 1'b0;
          swap_ready = 1'($urandom_range(0, 1));
        end
        pv = swap_valid;
        pc = c;
      end
    end
  end

  task automatic start_game(input logic [1:0] m, input bit slow, input bit extra);
    int exp_n, bad;
    bit done;
    hs_q.delete();
    ready_slow = slow;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_moves = 0;
    chk("busy_rise", busy, 1);
    chk("solved_clr", solved, 0);
    exp_n = (4 << m) + (extra ? 1 : 0);
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      tick();
      if (extra && hs_q.size() >= exp_n) is_correct = 1'b0;
      if (!busy) done = 1'b1;
    end
    chk("scr_done", done, 1);
    bad = 0;
    foreach (hs_q[k])
      if (hs_q[k].a >= 3'd6 || hs_q[k].b >= 3'd6 || hs_q[k].a == hs_q[k].b) bad++;
    chk("scr_cmds", hs_q.size(), exp_n);
    chk("scr_legal", bad, 0);
    chk("scr_state", 32'(dut.state_q), 32'(PLAY));
    chk("scr_moves", move_count, exp_moves);
    $display("game mode=%0d slow=%0d extra=%0d swaps=%0d", m, slow, extra, hs_q.size());
    hs_q.delete();
  endtask

  task automatic do_move(input logic [2:0] x, input logic [2:0] y, input int hold);
    pi1 = x;
    pi2 = y;
    change = 1'b1;
    repeat (hold) tick();
    change = 1'b0;
    repeat (5) tick();
  endtask

  // One user move checked against the model: legality decides command vs pulse.
  task automatic move_and_check(input logic [2:0] x, input logic [2:0] y, input int hold);
    int  hs0, il0;
    bit  legal;
    cmd_t c;
    legal = (x < 3'd6) && (y < 3'd6) && (x != y);
    hs0 = hs_q.size();
    il0 = illegal_seen;
    do_move(x, y, hold);
    if (legal) exp_moves = (exp_moves < 255) ? exp_moves + 1 : 255;
    chk("mv_cmds", hs_q.size() - hs0, legal ? 1 : 0);
    chk("mv_illegal", illegal_seen - il0, legal ? 0 : 1);
    chk("mv_count", move_count, exp_moves);
    if (legal && hs_q.size() > hs0) begin
      c = hs_q[hs_q.size() - 1];
      chk("mv_pair", {c.a, c.b}, {x, y});
    end
    $display("move pi1=%0d pi2=%0d hold=%0d moves=%0d", x, y, hold, move_count);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[6];
    int   hs0;
    vecs[0] = '{3'd0, 3'd1, 1'b1};
    vecs[1] = '{3'd6, 3'd2, 1'b0};
    vecs[2] = '{3'd3, 3'd3, 1'b0};
    vecs[3] = '{3'd5, 3'd4, 1'b1};
    vecs[4] = '{3'd7, 3'd0, 1'b0};
    vecs[5] = '{3'd2, 3'd5, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {swap_valid, swap_a, swap_b, busy, solved, illegal, move_count}, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    tick();

    start_game(2'b00, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      hs0 = hs_q.size();
      move_and_check(vecs[i].p1, vecs[i].p2, 1);
      chk("vec_legal", hs_q.size() - hs0, vecs[i].legal ? 1 : 0);
    end

    move_and_check(3'd0, 3'd1, 10);

    for (int i = 0; i < 30; i++)
      move_and_check(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1);

    for (int i = 0; i < 256; i++) begin
      do_move(3'd2, 3'd4, 1);
      exp_moves = (exp_moves < 255) ? exp_moves + 1 : 255;
    end
    chk("mv_saturate", move_count, exp_moves);
    hs_q.delete();

    is_correct = 1'b1;
    move_and_check(3'd0, 3'd1, 1);
    chk("solved_set", solved, 1);
    hs0 = hs_q.size();
    do_move(3'd1, 3'd2, 1);
    chk("solved_ignore_cmd", hs_q.size() - hs0, 0);
    chk("solved_hold", solved, 1);
    chk("solved_moves", move_count, exp_moves);
    is_correct = 1'b0;

    start_game(2'b11, 1'b1, 1'b0);
    start_game(2'b01, 1'($urandom_range(0, 1)), 1'b0);
    start_game(2'b10, 1'($urandom_range(0, 1)), 1'b0);
    is_correct = 1'b1;
    start_game(2'b00, 1'b0, 1'b1);
    is_correct = 1'b0;

    chk("hs_stable", stab_err, 0);
    chk("hs_gap", gap_err, 0);

    // Reset in the middle of a held-off scramble command.
    hs_q.delete();
    ready_slow = 1'b1;
    mode  = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        if (swap_valid) seen = 1'b1;
        else tick();
      end
      chk("rst_mid_valid", seen, 1);
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", {swap_valid, swap_a, swap_b, busy, solved, illegal, move_count}, 0);
    chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) tick();
    chk("rst_mid_nocmd", hs_q.size(), 0);
    rst = 1'b0;
    tick();
    chk("rst_idle_hold", 32'(dut.state_q), 32'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
